// File: rtl/cpu_trap_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_trap_ctrl_pkg                                                          |
// | Shared constants for the trap sequencer: IRQ bit positions, mcause codes,  |
// | mtvec modes and the 2-bit exception code to mcause mapping.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package cpu_trap_ctrl_pkg;

   localparam int unsigned c_irq_mei_bit = 11;
   localparam int unsigned c_irq_msi_bit = 3;
   localparam int unsigned c_irq_mti_bit = 7;

   localparam logic [1:0] c_mtvec_mode_direct   = 2'b00;
   localparam logic [1:0] c_mtvec_mode_vectored = 2'b01;

   localparam logic [4:0] c_mcause_instr_addr_misaligned = 5'd0;
   localparam logic [4:0] c_mcause_illegal               = 5'd2;
   localparam logic [4:0] c_mcause_breakpoint            = 5'd3;
   localparam logic [4:0] c_mcause_ecall                 = 5'd11;

   // Compact W-stage exception code carried down the pipeline.
   typedef enum logic [1:0] {
      EXCAUSE_INSTR_ADDR_MISALIGNED = 2'd0,
      EXCAUSE_ILLEGAL               = 2'd1,
      EXCAUSE_BREAKPOINT            = 2'd2,
      EXCAUSE_ECALL                 = 2'd3
   } excause_e;

   function automatic logic [31:0] excause_to_mcause(input logic [1:0] code);
      logic [4:0] c;
      case (code)
         EXCAUSE_INSTR_ADDR_MISALIGNED: c = c_mcause_instr_addr_misaligned;
         EXCAUSE_ILLEGAL:               c = c_mcause_illegal;
         EXCAUSE_BREAKPOINT:            c = c_mcause_breakpoint;
         default:                       c = c_mcause_ecall;
      endcase
      return {27'd0, c};
   endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_trap_ctrl_irq_prio.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_irq_prio                                                               |
// | Combinational priority encoder over pending&enabled IRQs: MEI > MSI > MTI. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cpu_irq_prio
   import cpu_trap_ctrl_pkg::*;
(
   input  logic [31:0] pend_en,
   output logic        valid,
   output logic [4:0]  cause
);

   logic w_unused_pend;
   assign w_unused_pend = &{1'b0, pend_en};

   always_comb begin
      valid = 1'b0;
      cause = 5'd0;
      if (pend_en[c_irq_mei_bit]) begin
         valid = 1'b1;
         cause = 5'(c_irq_mei_bit);
      end else if (pend_en[c_irq_msi_bit]) begin
         valid = 1'b1;
         cause = 5'(c_irq_msi_bit);
      end else if (pend_en[c_irq_mti_bit]) begin
         valid = 1'b1;
         cause = 5'(c_irq_mti_bit);
      end
   end

endmodule
`default_nettype wire

// File: rtl/cpu_trap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_trap_ctrl                                                              |
// | Trap sequencer between W stage and CSR file: arbitrates interrupts,        |
// | exceptions and mret, redirects fetch and holds flush while younger work    |
// | drains. Option macro CPU_TRAP_VECTORED_EN enables vectored interrupts.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cpu_trap_ctrl
   import cpu_trap_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 3
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bubble_w,
   input  logic        exception_w,
   input  logic [1:0]  exception_cause_w,
   input  logic        mret_w,
   input  logic [31:0] pc_w,
   input  logic        irq_ext,
   input  logic        irq_sw,
   input  logic        irq_timer,
   input  logic        mstatus_mie,
   input  logic [31:0] mie,
   input  logic [31:0] mtvec,
   input  logic [31:0] mepc,
   output logic        kill_w,
   output logic        trap_enter,
   output logic        trap_mret,
   output logic [31:0] trap_cause,
   output logic [31:0] trap_epc,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        flush,
   output logic [31:0] irq_pending
);

   localparam int unsigned c_cnt_w = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_ENTER  = 2'd1,
      S_RETURN = 2'd2,
      S_FLUSH  = 2'd3
   } state_e;

   state_e             r_state;
   logic [c_cnt_w-1:0] r_flush_cnt;
   logic               r_trap_enter;
   logic               r_trap_mret;
   logic [31:0]        r_trap_cause;
   logic [31:0]        r_trap_epc;
   logic               r_redirect_valid;
   logic [31:0]        r_redirect_pc;
   logic               r_flush;
   logic [31:0]        r_irq_pending;

   logic [31:0] w_irq_pending_next;
   logic        w_irq_valid;
   logic [4:0]  w_irq_cause;
   logic        w_run;
   logic        w_irq_take;
   logic        w_exc_take;
   logic        w_mret_take;
   logic [31:0] w_base;
   logic [31:0] w_irq_target;

   always_comb begin
      w_irq_pending_next                = 32'd0;
      w_irq_pending_next[c_irq_mei_bit] = irq_ext;
      w_irq_pending_next[c_irq_mti_bit] = irq_timer;
      w_irq_pending_next[c_irq_msi_bit] = irq_sw;
   end

   cpu_irq_prio u_irq_prio (
      .pend_en (r_irq_pending & mie),
      .valid   (w_irq_valid),
      .cause   (w_irq_cause)
   );

   assign w_run       = (r_state == S_RUN);
   assign w_irq_take  = w_run & mstatus_mie & ~bubble_w & w_irq_valid;
   assign w_exc_take  = w_run & exception_w & ~bubble_w;
   assign w_mret_take = w_run & mret_w & ~bubble_w & ~exception_w;
   assign w_base      = {mtvec[31:2], 2'b00};

`ifdef CPU_TRAP_VECTORED_EN
   assign w_irq_target = (mtvec[1:0] == c_mtvec_mode_vectored)
                         ? w_base + {25'd0, w_irq_cause, 2'b00} : w_base;
`else
   logic w_unused_mode;
   assign w_unused_mode = &{1'b0, mtvec[1:0], c_mtvec_mode_vectored, c_mtvec_mode_direct};
   assign w_irq_target  = w_base;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state          <= S_RUN;
         r_flush_cnt      <= '0;
         r_trap_enter     <= 1'b0;
         r_trap_mret      <= 1'b0;
         r_trap_cause     <= 32'd0;
         r_trap_epc       <= 32'd0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= 32'd0;
         r_flush          <= 1'b0;
         r_irq_pending    <= 32'd0;
      end else begin
         r_irq_pending    <= w_irq_pending_next;
         r_trap_enter     <= 1'b0;
         r_trap_mret      <= 1'b0;
         r_redirect_valid <= 1'b0;
         case (r_state)
            S_RUN: begin
               // Interrupt wins; any exception of the killed W instruction is dropped.
               if (w_irq_take) begin
                  r_state          <= S_ENTER;
                  r_trap_enter     <= 1'b1;
                  r_redirect_valid <= 1'b1;
                  r_flush          <= 1'b1;
                  r_trap_cause     <= {1'b1, 26'd0, w_irq_cause};
                  r_trap_epc       <= pc_w;
                  r_redirect_pc    <= w_irq_target;
               end else if (w_exc_take) begin
                  r_state          <= S_ENTER;
                  r_trap_enter     <= 1'b1;
                  r_redirect_valid <= 1'b1;
                  r_flush          <= 1'b1;
                  r_trap_cause     <= excause_to_mcause(exception_cause_w);
                  r_trap_epc       <= pc_w;
                  r_redirect_pc    <= w_base;
               end else if (w_mret_take) begin
                  r_state          <= S_RETURN;
                  r_trap_mret      <= 1'b1;
                  r_redirect_valid <= 1'b1;
                  r_flush          <= 1'b1;
                  r_redirect_pc    <= mepc;
               end
            end
            S_ENTER, S_RETURN: begin
               if (FLUSH_CYCLES > 0) begin
                  r_state     <= S_FLUSH;
                  r_flush_cnt <= c_cnt_w'(FLUSH_CYCLES);
               end else begin
                  r_state <= S_RUN;
                  r_flush <= 1'b0;
               end
            end
            S_FLUSH: begin
               if (r_flush_cnt <= c_cnt_w'(1)) begin
                  r_state     <= S_RUN;
                  r_flush     <= 1'b0;
                  r_flush_cnt <= '0;
               end else begin
                  r_flush_cnt <= r_flush_cnt - 1'b1;
               end
            end
            default: r_state <= S_RUN;
         endcase
      end
   end

   assign kill_w         = w_irq_take;
   assign trap_enter     = r_trap_enter;
   assign trap_mret      = r_trap_mret;
   assign trap_cause     = r_trap_cause;
   assign trap_epc       = r_trap_epc;
   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;
   assign flush          = r_flush;
   assign irq_pending    = r_irq_pending;

endmodule
`default_nettype wire
